// File: rtl/lcdi_interp_engine.sv
// LCDI interpolation engine: two channels x two phases of TAPS-tap weighted sums,
// coefficients fetched from an external 1-cycle-latency ROM, rounded and saturated to pixels.
//
// state  | meaning
// IDLE   | ready; a start latches taps and index and drives the upper ROM address
// WAIT_U | ROM samples the upper address; phase select moves to lower
// MUL_U  | upper coefficients present; upper products registered
// MUL_L  | lower coefficients present; upper pixels produced, lower products registered
// SUM_L  | lower pixels produced; write strobe follows
module lcdi_interp_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 10,
    parameter int TAPS        = 3,
    parameter int FRAC_BITS   = 8,
    parameter int INDEX_WIDTH = 7,
    parameter int ROUND_EN    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [INDEX_WIDTH-1:0]            index,
    input  logic [TAPS*DATA_WIDTH-1:0]        pix_in,
    output logic                              ready,
    output logic [INDEX_WIDTH-1:0]            coeff_addr,
    output logic                              coeff_sel,
    input  logic [2*TAPS*COEFF_WIDTH-1:0]     coeff_data,
    output logic [DATA_WIDTH-1:0]             data0_out,
    output logic [DATA_WIDTH-1:0]             data1_out,
    output logic [DATA_WIDTH-1:0]             data2_out,
    output logic [DATA_WIDTH-1:0]             data3_out,
    output logic                              write_enable
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_ADD =
        (ROUND_EN != 0) ? RND_W'(2 ** (FRAC_BITS - 1)) : '0;
    localparam logic signed [RND_W-1:0] PIX_MAX = RND_W'(2 ** DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_U = 3'd1,
        MUL_U  = 3'd2,
        MUL_L  = 3'd3,
        SUM_L  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                         accept;
    logic [DATA_WIDTH-1:0]        pix_q  [TAPS];
    logic signed [PROD_W-1:0]     prod_d [2*TAPS];
    logic signed [PROD_W-1:0]     prod_q [2*TAPS];
    logic signed [ACC_W-1:0]      sum_ch0;
    logic signed [ACC_W-1:0]      sum_ch1;

    assign ready  = (state == IDLE);
    assign accept = ready & start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT_U;
            WAIT_U:  state_nxt = MUL_U;
            MUL_U:   state_nxt = MUL_L;
            MUL_L:   state_nxt = SUM_L;
            SUM_L:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Taps and index are captured once per request; coeff_addr doubles as the latched index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) pix_q[t] <= '0;
            coeff_addr <= '0;
            coeff_sel  <= 1'b0;
        end else if (accept) begin
            for (int t = 0; t < TAPS; t++) pix_q[t] <= pix_in[t*DATA_WIDTH +: DATA_WIDTH];
            coeff_addr <= index;
            coeff_sel  <= 1'b0;
        end else if (state == WAIT_U) begin
            coeff_sel  <= 1'b1;
        end
    end

    // One multiplier bank serves both phases; the ROM word in flight selects which.
    for (genvar i = 0; i < 2*TAPS; i++) begin : g_mul
        logic signed [PROD_W-1:0] mul_a;
        logic signed [PROD_W-1:0] mul_b;
        assign mul_a     = PROD_W'({1'b0, pix_q[i % TAPS]});
        assign mul_b     = PROD_W'($signed(coeff_data[i*COEFF_WIDTH +: COEFF_WIDTH]));
        assign prod_d[i] = mul_a * mul_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2*TAPS; i++) prod_q[i] <= '0;
        end else if (state == MUL_U || state == MUL_L) begin
            for (int i = 0; i < 2*TAPS; i++) prod_q[i] <= prod_d[i];
        end
    end

    always_comb begin
        sum_ch0 = '0;
        sum_ch1 = '0;
        for (int t = 0; t < TAPS; t++) begin
            sum_ch0 = sum_ch0 + ACC_W'(prod_q[t]);
            sum_ch1 = sum_ch1 + ACC_W'(prod_q[TAPS + t]);
        end
    end

    // One extra bit keeps the rounding increment from wrapping before the high clamp.
    function automatic logic [DATA_WIDTH-1:0] sat_round(input logic signed [ACC_W-1:0] s);
        logic signed [RND_W-1:0] r;
        logic signed [RND_W-1:0] q;
        r = RND_W'(s) + RND_ADD;
        q = r >>> FRAC_BITS;
        if (q[RND_W-1]) begin
            return '0;
        end else if (q > PIX_MAX) begin
            return '1;
        end
        return q[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0_out    <= '0;
            data1_out    <= '0;
            data2_out    <= '0;
            data3_out    <= '0;
            write_enable <= 1'b0;
        end else begin
            write_enable <= (state == SUM_L);
            if (state == MUL_L) begin
                data0_out <= sat_round(sum_ch0);
                data1_out <= sat_round(sum_ch1);
            end
            if (state == SUM_L) begin
                data2_out <= sat_round(sum_ch0);
                data3_out <= sat_round(sum_ch1);
            end
        end
    end

endmodule

// File: tb/tb_lcdi_interp_engine.sv
// Bench for lcdi_interp_engine: a rounding and a truncating instance share stimulus and a ROM
// image; a scoreboard of model results is drained by a monitor on write_enable.
module tb_lcdi_interp_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  index;
    logic [23:0] pix_in;

    logic        ready_r, ready_t;
    logic [6:0]  addr_r, addr_t;
    logic        sel_r, sel_t;
    logic [59:0] cd_r, cd_t;
    logic [7:0]  r0, r1, r2, r3, t0, t1, t2, t3;
    logic        we_r, we_t;

    always #5 clk = ~clk;

    lcdi_interp_engine #(.ROUND_EN(1)) dut_rnd (
        .clk(clk), .rst(rst), .start(start), .index(index), .pix_in(pix_in),
        .ready(ready_r), .coeff_addr(addr_r), .coeff_sel(sel_r), .coeff_data(cd_r),
        .data0_out(r0), .data1_out(r1), .data2_out(r2), .data3_out(r3),
        .write_enable(we_r)
    );

    lcdi_interp_engine #(.ROUND_EN(0)) dut_trn (
        .clk(clk), .rst(rst), .start(start), .index(index), .pix_in(pix_in),
        .ready(ready_t), .coeff_addr(addr_t), .coeff_sel(sel_t), .coeff_data(cd_t),
        .data0_out(t0), .data1_out(t1), .data2_out(t2), .data3_out(t3),
        .write_enable(we_t)
    );

    // rom[index][phase][channel][tap], signed coefficient values
    int rom [128][2][2][3];

    typedef struct packed {
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  d3;
        logic [31:0] cyc;
    } exp_t;

    exp_t q_r[$];
    exp_t q_t[$];
    exp_t e_r, e_t;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [59:0] rom_word(input logic [6:0] a, input logic s);
        logic [59:0] w;
        w = '0;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 3; t++)
                w[(c*3+t)*10 +: 10] = 10'(rom[a][s][c][t]);
        return w;
    endfunction

    always @(posedge clk) begin
        cd_r <= rom_word(addr_r, sel_r);
        cd_t <= rom_word(addr_t, sel_t);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: integer weighted sum, optional half-up rounding, floor divide, clamp.
    function automatic int ref_px(input int idx, input int ph, input int ch,
                                  input int p0, input int p1, input int p2, input bit rnd);
        int s;
        s = p0 * rom[idx][ph][ch][0] + p1 * rom[idx][ph][ch][1] + p2 * rom[idx][ph][ch][2];
        if (rnd) s = s + 128;
        s = s >>> 8;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic push_exp(input int idx, input int p0, input int p1, input int p2);
        exp_t e;
        e.cyc = 32'(cyc + 4);
        e.d0 = 8'(ref_px(idx, 0, 0, p0, p1, p2, 1'b1));
        e.d1 = 8'(ref_px(idx, 0, 1, p0, p1, p2, 1'b1));
        e.d2 = 8'(ref_px(idx, 1, 0, p0, p1, p2, 1'b1));
        e.d3 = 8'(ref_px(idx, 1, 1, p0, p1, p2, 1'b1));
        q_r.push_back(e);
        e.d0 = 8'(ref_px(idx, 0, 0, p0, p1, p2, 1'b0));
        e.d1 = 8'(ref_px(idx, 0, 1, p0, p1, p2, 1'b0));
        e.d2 = 8'(ref_px(idx, 1, 0, p0, p1, p2, 1'b0));
        e.d3 = 8'(ref_px(idx, 1, 1, p0, p1, p2, 1'b0));
        q_t.push_back(e);
    endtask

    task automatic cmp(input string tag, input exp_t e,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3);
        chk({tag, "_latency"}, cyc, int'(e.cyc));
        chk({tag, "_data0"}, int'(a0), int'(e.d0));
        chk({tag, "_data1"}, int'(a1), int'(e.d1));
        chk({tag, "_data2"}, int'(a2), int'(e.d2));
        chk({tag, "_data3"}, int'(a3), int'(e.d3));
    endtask

    // Monitor: every write strobe must match the oldest outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (we_r) begin
                    if (q_r.size() == 0) chk("rnd_unexpected_we", 1, 0);
                    else begin
                        e_r = q_r.pop_front();
                        cmp("rnd", e_r, r0, r1, r2, r3);
                    end
                end
                if (we_t) begin
                    if (q_t.size() == 0) chk("trn_unexpected_we", 1, 0);
                    else begin
                        e_t = q_t.pop_front();
                        cmp("trn", e_t, t0, t1, t2, t3);
                    end
                end
            end
        end
    end

    task automatic set_rom(input int idx, input int ph, input int ch,
                           input int c0, input int c1, input int c2);
        rom[idx][ph][ch][0] = c0;
        rom[idx][ph][ch][1] = c1;
        rom[idx][ph][ch][2] = c2;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ready"}, int'(ready_r), 1);
        chk({tag, "_addr"},  int'(addr_r), 0);
        chk({tag, "_sel"},   int'(sel_r), 0);
        chk({tag, "_we"},    int'(we_r), 0);
        chk({tag, "_data"},  int'({r0, r1, r2, r3}), 0);
        chk({tag, "_trn_data"}, int'({t0, t1, t2, t3}), 0);
    endtask

    // Issue one request at the first idle cycle; junk start/index during busy must be ignored.
    task automatic do_req(input int idx, input int p0, input int p1, input int p2);
        @(negedge clk);
        start  = 1'b1;
        index  = 7'(idx);
        pix_in = {8'(p2), 8'(p1), 8'(p0)};
        chk("ready_idle", int'(ready_r), 1);
        @(posedge clk); #1;
        push_exp(idx, p0, p1, p2);
        chk("addr_on_accept", int'(addr_r), idx);
        chk("sel_upper", int'(sel_r), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("ready_busy", int'(ready_r), 0);
            start  = 1'($urandom);
            index  = 7'($urandom);
            pix_in = 24'($urandom);
            @(posedge clk); #1;
            if (k == 1) chk("sel_lower", int'(sel_t), 1);
            chk("addr_hold", int'(addr_r), idx);
        end
        start = 1'b0;
    endtask

    int acc_idx;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        index  = '0;
        pix_in = '0;

        for (int i = 0; i < 128; i++)
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < 2; c++)
                    for (int t = 0; t < 3; t++)
                        rom[i][s][c][t] = int'($urandom_range(1023)) - 512;
        set_rom(1, 0, 0, 85, 86, 85);
        set_rom(5, 1, 1, 256, 0, 0);
        set_rom(2, 0, 0, 511, 511, 0);
        set_rom(6, 0, 0, -64, 0, 0);
        set_rom(3, 1, 0, 128, 0, 0);
        set_rom(4, 0, 0, 511, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        do_req(1, 100, 100, 100);
        chk("avg_rnd", int'(r0), 100);
        chk("avg_trn", int'(t0), 100);
        do_req(5, 37, 200, 9);
        chk("unity_rnd", int'(r3), 37);
        chk("unity_trn", int'(t3), 37);
        do_req(2, 255, 255, 0);
        chk("sat_high", int'(r0), 255);
        do_req(6, 50, 17, 250);
        chk("sat_low", int'(r0), 0);
        do_req(3, 3, 90, 140);
        chk("half_round", int'(r2), 2);
        chk("half_trunc", int'(t2), 1);
        do_req(4, 128, 60, 70);
        chk("round_ovf_rnd", int'(r0), 255);
        chk("round_ovf_trn", int'(t0), 255);

        // Abort mid-request; no strobe may follow and a fresh request must complete.
        @(negedge clk);
        start  = 1'b1;
        index  = 7'd9;
        pix_in = 24'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        q_r.delete();
        q_t.delete();
        @(negedge clk);
        check_idle_zero("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("post_reset");
        do_req(10, 11, 22, 33);

        for (int n = 0; n < 40; n++) begin
            do_req(int'($urandom_range(127)), int'($urandom_range(255)),
                   int'($urandom_range(255)), int'($urandom_range(255)));
            repeat ($urandom_range(2)) @(posedge clk);
        end

        // start held high: accepts land every fifth cycle, index changes in between are ignored.
        acc_idx = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start  = 1'b1;
            index  = 7'($urandom);
            pix_in = 24'($urandom);
            chk("held_ready", int'(ready_r), (i % 5 == 0) ? 1 : 0);
            @(posedge clk); #1;
            if (i % 5 == 0) begin
                push_exp(int'(index), int'(pix_in[7:0]), int'(pix_in[15:8]), int'(pix_in[23:16]));
                acc_idx = int'(index);
            end
            chk("held_addr", int'(addr_r), acc_idx);
        end
        start = 1'b0;

        for (int w = 0; w < 20 && (q_r.size() != 0 || q_t.size() != 0); w++) @(posedge clk);
        @(negedge clk);
        chk("drain_rnd", q_r.size(), 0);
        chk("drain_trn", q_t.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
